dcfifo_s_wr_ctrl: RTL

Write-side pointer and flag controller for the dual-clock FIFO `dcfifo_s`. It runs entirely in the write clock domain (`din_clk`) and accepts write requests while the FIFO is not full. It drives the RAM write port and produces the registered Gray-coded write pointer that feeds the pointer synchronizer into the read domain. It also consumes the read-side Gray pointer, already synchronized into `din_clk`, to compute `full` and the used-word count.

---
 rtl/dcfifo_s_wr_ctrl.sv | 60 ++++++
 1 files changed

// File: rtl/dcfifo_s_wr_ctrl.sv
// Write-side pointer and flag controller for the dual-clock FIFO dcfifo_s.
// Runs in din_clk; consumes the read Gray pointer already synchronized into this domain.
module dcfifo_s_wr_ctrl #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  din_clk,
  input  logic                  aclr,
  input  logic                  wrreq,
  input  logic [ADDR_WIDTH:0]   rd_gray_sync,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [ADDR_WIDTH:0]   wr_gray,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   wrusedw,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH:0] wr_bin;
  logic [ADDR_WIDTH:0] wr_bin_nxt;
  logic [ADDR_WIDTH:0] rd_bin;
  logic [ADDR_WIDTH:0] used_nxt;
  logic                wr_acc;

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
    logic [ADDR_WIDTH:0] b;
    b = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  // full is low during reset, so aclr must gate the enable explicitly.
  assign wr_acc     = wrreq & ~full & ~aclr;
  assign ram_we     = wr_acc;
  assign ram_waddr  = wr_bin[ADDR_WIDTH-1:0];
  assign wr_bin_nxt = wr_bin + {{ADDR_WIDTH{1'b0}}, wr_acc};
  assign rd_bin     = gray2bin(rd_gray_sync);
  assign used_nxt   = wr_bin_nxt - rd_bin;

  always_ff @(posedge din_clk or posedge aclr) begin
    if (aclr) begin
      wr_bin   <= '0;
      wr_gray  <= '0;
      wrusedw  <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_bin   <= wr_bin_nxt;
      wr_gray  <= wr_bin_nxt ^ (wr_bin_nxt >> 1);
      wrusedw  <= used_nxt;
      full     <= (used_nxt == DEPTH);
      overflow <= wrreq & full;
    end
  end

endmodule
